// File: rtl/qp_mem_arb_if.sv
// Requester-side bus of the query-patch SRAM arbiter: one instance per master.
// The requester drives req/we/addr/wdata and receives gnt plus the read return.
interface qp_mem_arb_if #(
  parameter int ADDRW = 9,
  parameter int PW    = 55
);
  logic             req;
  logic             we;
  logic [ADDRW-1:0] addr;
  logic [PW-1:0]    wdata;
  logic             gnt;
  logic             rvalid;
  logic [PW-1:0]    rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/qp_mem_arb.sv
// Two-requester arbiter for the single-port query-patch SRAM.
// The accelerator (acc) and the Wishbone controller (wbs) share the macro
// with bounded-burst round-robin. Grants and SRAM pins are combinational.
// Read data is steered back only to the requester that issued the read.
// In debug mode only the Wishbone side can be granted.
module qp_mem_arb #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int NUM_QUERYS = 494,
  parameter int ADDRW      = $clog2(NUM_QUERYS),
  parameter int MAX_BURST  = 4,
  localparam int PW        = PATCH_SIZE * DATA_WIDTH
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_debug,
  qp_mem_arb_if.slave      acc,
  qp_mem_arb_if.slave      wbs,
  output logic             mem_csb0,
  output logic             mem_web0,
  output logic [ADDRW-1:0] mem_addr0,
  output logic [PW-1:0]    mem_wpatch0,
  input  logic [PW-1:0]    mem_rpatch0
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic          OWN_ACC = 1'b0;
  localparam logic          OWN_WBS = 1'b1;

  // Burst / ownership state
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  // Read return pipeline
  logic          rd_pend_q, rd_pend_d;
  logic          rd_own_q, rd_own_d;
  logic          acc_rvalid_q, acc_rvalid_d;
  logic          wbs_rvalid_q, wbs_rvalid_d;
  logic [PW-1:0] acc_rdata_q, acc_rdata_d;
  logic [PW-1:0] wbs_rdata_q, wbs_rdata_d;

  // Arbitration results
  logic             acc_win_s;
  logic             wbs_win_s;
  logic             tie_wbs_s;
  logic             any_gnt_s;
  logic             win_id_s;
  logic             win_we_s;
  logic [ADDRW-1:0] win_addr_s;
  logic [PW-1:0]    win_wdata_s;

  // Pick at most one winner this cycle.
  always_comb begin
    acc_win_s = 1'b0;
    wbs_win_s = 1'b0;
    tie_wbs_s = 1'b0;
    if (wbs_debug) begin
      // Debug lock: acc never wins, wbs wins whenever it asks.
      wbs_win_s = wbs.req;
    end else if (acc.req && wbs.req) begin
      if (burst_cnt_q == {CW{1'b0}}) begin
        // No burst in progress: alternate away from the last winner.
        tie_wbs_s = (last_owner_q == OWN_ACC);
      end else if (burst_cnt_q < MAX_CNT) begin
        // Owner may continue its burst.
        tie_wbs_s = (owner_q == OWN_WBS);
      end else begin
        // Burst exhausted: hand over to the waiting requester.
        tie_wbs_s = (owner_q == OWN_ACC);
      end
      wbs_win_s = tie_wbs_s;
      acc_win_s = ~tie_wbs_s;
    end else begin
      acc_win_s = acc.req;
      wbs_win_s = wbs.req;
    end
  end

  assign any_gnt_s = acc_win_s | wbs_win_s;
  assign acc.gnt   = acc_win_s;
  assign wbs.gnt   = wbs_win_s;

  // Multiplex the winner onto the SRAM pins; idle pins are parked.
  always_comb begin
    win_id_s    = OWN_ACC;
    win_we_s    = 1'b0;
    win_addr_s  = {ADDRW{1'b0}};
    win_wdata_s = {PW{1'b0}};
    if (wbs_win_s) begin
      win_id_s    = OWN_WBS;
      win_we_s    = wbs.we;
      win_addr_s  = wbs.addr;
      win_wdata_s = wbs.wdata;
    end else if (acc_win_s) begin
      win_id_s    = OWN_ACC;
      win_we_s    = acc.we;
      win_addr_s  = acc.addr;
      win_wdata_s = acc.wdata;
    end else begin
      win_id_s    = OWN_ACC;
      win_we_s    = 1'b0;
      win_addr_s  = {ADDRW{1'b0}};
      win_wdata_s = {PW{1'b0}};
    end
    mem_csb0    = ~any_gnt_s;
    mem_web0    = any_gnt_s ? ~win_we_s : 1'b1;
    mem_addr0   = win_addr_s;
    mem_wpatch0 = win_wdata_s;
  end

  // Next burst/ownership state and read-return pipeline.
  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    if (any_gnt_s) begin
      last_owner_d = win_id_s;
      if (win_id_s == owner_q) begin
        if (burst_cnt_q < MAX_CNT) begin
          burst_cnt_d = burst_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end else begin
        owner_d     = win_id_s;
        burst_cnt_d = {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      // An idle cycle ends any burst; ownership is remembered.
      burst_cnt_d = {CW{1'b0}};
    end

    rd_pend_d = any_gnt_s & ~win_we_s;
    rd_own_d  = win_id_s;

    // SRAM output is valid the cycle after the read select; capture it
    // for the issuing requester only and pulse its rvalid alongside.
    acc_rvalid_d = rd_pend_q & (rd_own_q == OWN_ACC);
    wbs_rvalid_d = rd_pend_q & (rd_own_q == OWN_WBS);
    acc_rdata_d  = acc_rvalid_d ? mem_rpatch0 : acc_rdata_q;
    wbs_rdata_d  = wbs_rvalid_d ? mem_rpatch0 : wbs_rdata_q;
  end

  // State registers with synchronous reset; reset drops any pending read.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      owner_q      <= OWN_ACC;
      last_owner_q <= OWN_WBS;
      burst_cnt_q  <= {CW{1'b0}};
      rd_pend_q    <= 1'b0;
      rd_own_q     <= OWN_ACC;
      acc_rvalid_q <= 1'b0;
      wbs_rvalid_q <= 1'b0;
      acc_rdata_q  <= {PW{1'b0}};
      wbs_rdata_q  <= {PW{1'b0}};
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_own_q     <= rd_own_d;
      acc_rvalid_q <= acc_rvalid_d;
      wbs_rvalid_q <= wbs_rvalid_d;
      acc_rdata_q  <= acc_rdata_d;
      wbs_rdata_q  <= wbs_rdata_d;
    end
  end

  assign acc.rvalid = acc_rvalid_q;
  assign acc.rdata  = acc_rdata_q;
  assign wbs.rvalid = wbs_rvalid_q;
  assign wbs.rdata  = wbs_rdata_q;

endmodule

// File: tb/tb_qp_mem_arb.sv
// Directed bench for qp_mem_arb with a behavioural single-port SRAM model.
module tb_qp_mem_arb;
  localparam int DW    = 11;
  localparam int PS    = 5;
  localparam int NQ    = 494;
  localparam int AW    = $clog2(NQ);
  localparam int PW    = DW * PS;
  localparam int MB    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dbg = 1'b0;
  logic          mem_csb0;
  logic          mem_web0;
  logic [AW-1:0] mem_addr0;
  logic [PW-1:0] mem_wpatch0;
  logic [PW-1:0] mem_rpatch0 = '0;

  int checks = 0;
  int errors = 0;

  qp_mem_arb_if #(.ADDRW(AW), .PW(PW)) acc_if ();
  qp_mem_arb_if #(.ADDRW(AW), .PW(PW)) wbs_if ();

  qp_mem_arb #(
    .DATA_WIDTH(DW), .PATCH_SIZE(PS), .NUM_QUERYS(NQ), .ADDRW(AW), .MAX_BURST(MB)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_debug   (dbg),
    .acc         (acc_if),
    .wbs         (wbs_if),
    .mem_csb0    (mem_csb0),
    .mem_web0    (mem_web0),
    .mem_addr0   (mem_addr0),
    .mem_wpatch0 (mem_wpatch0),
    .mem_rpatch0 (mem_rpatch0)
  );

  always #5 clk = ~clk;

  // SRAM model: unwritten locations return a fixed per-address pattern.
  logic [PW-1:0] mem_wr [0:NQ-1];
  bit            mem_wv [0:NQ-1];

  function automatic logic [PW-1:0] pat(input int a);
    case (a)
      5:       pat = 55'h12345;
      10:      pat = 55'hA0A;
      20:      pat = 55'hB0B;
      default: pat = PW'(a * 3 + 1);
    endcase
  endfunction

  always @(posedge clk) begin
    if (!mem_csb0) begin
      if (!mem_web0) begin
        mem_wr[mem_addr0] <= mem_wpatch0;
        mem_wv[mem_addr0] <= 1'b1;
      end else begin
        mem_rpatch0 <= mem_wv[mem_addr0] ? mem_wr[mem_addr0] : pat(int'(mem_addr0));
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (start of next cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    acc_if.req = 1'b0; acc_if.we = 1'b0; acc_if.addr = '0; acc_if.wdata = '0;
    wbs_if.req = 1'b0; wbs_if.we = 1'b0; wbs_if.addr = '0; wbs_if.wdata = '0;
  endtask

  // Leaves the bench at the start of "cycle 0" with reset released.
  task automatic do_reset();
    tick();
    rst = 1'b1;
    dbg = 1'b0;
    idle_reqs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_reqs();

    // ---------------- Test 1: reset values and a single acc read
    do_reset();
    #2;
    chk("rst_acc_rvalid", 64'(acc_if.rvalid), 64'd0);
    chk("rst_wbs_rvalid", 64'(wbs_if.rvalid), 64'd0);
    chk("rst_acc_rdata",  64'(acc_if.rdata),  64'd0);
    chk("rst_wbs_rdata",  64'(wbs_if.rdata),  64'd0);
    chk("idle_csb0",      64'(mem_csb0),      64'd1);
    chk("idle_web0",      64'(mem_web0),      64'd1);
    acc_if.req = 1'b1; acc_if.we = 1'b0; acc_if.addr = 9'd5;
    #2;
    chk("t1_acc_gnt",  64'(acc_if.gnt), 64'd1);
    chk("t1_wbs_gnt",  64'(wbs_if.gnt), 64'd0);
    chk("t1_csb0",     64'(mem_csb0),   64'd0);
    chk("t1_web0",     64'(mem_web0),   64'd1);
    chk("t1_addr0",    64'(mem_addr0),  64'd5);
    tick();
    idle_reqs();
    #2;
    chk("t1_c1_acc_rvalid", 64'(acc_if.rvalid), 64'd0);
    chk("t1_c1_csb0",       64'(mem_csb0),      64'd1);
    tick();
    #2;
    chk("t1_c2_acc_rvalid", 64'(acc_if.rvalid), 64'd1);
    chk("t1_c2_acc_rdata",  64'(acc_if.rdata),  64'h12345);
    chk("t1_c2_wbs_rvalid", 64'(wbs_if.rvalid), 64'd0);
    tick();
    #2;
    chk("t1_c3_acc_rvalid", 64'(acc_if.rvalid), 64'd0);
    chk("t1_c3_acc_rdata",  64'(acc_if.rdata),  64'h12345);

    // ---------------- Test 2: both read continuously, bursts of 4
    do_reset();
    begin
      bit exp_wbs [0:13];
      acc_if.req = 1'b1; acc_if.addr = 9'd10;
      wbs_if.req = 1'b1; wbs_if.addr = 9'd20;
      for (int i = 0; i < 14; i++) begin
        if (i == 12) idle_reqs();
        #2;
        if (i < 12) begin
          exp_wbs[i] = ((i / 4) % 2) == 1;
          chk($sformatf("t2_acc_gnt_%0d", i), 64'(acc_if.gnt), 64'(!exp_wbs[i]));
          chk($sformatf("t2_wbs_gnt_%0d", i), 64'(wbs_if.gnt), 64'(exp_wbs[i]));
        end
        if (i >= 2) begin
          chk($sformatf("t2_acc_rv_%0d", i), 64'(acc_if.rvalid), 64'(!exp_wbs[i-2]));
          chk($sformatf("t2_wbs_rv_%0d", i), 64'(wbs_if.rvalid), 64'(exp_wbs[i-2]));
          if (exp_wbs[i-2]) chk($sformatf("t2_wbs_rd_%0d", i), 64'(wbs_if.rdata), 64'hB0B);
          else              chk($sformatf("t2_acc_rd_%0d", i), 64'(acc_if.rdata), 64'hA0A);
        end
        tick();
      end
    end

    // ---------------- Test 3: debug lock, pending acc read still returns
    do_reset();
    acc_if.req = 1'b1; acc_if.addr = 9'd5;
    #2;
    chk("t3_c0_acc_gnt", 64'(acc_if.gnt), 64'd1);
    tick();
    dbg = 1'b1;
    wbs_if.req = 1'b1; wbs_if.addr = 9'd20;
    for (int i = 1; i <= 10; i++) begin
      #2;
      chk($sformatf("t3_dbg_wbs_gnt_%0d", i), 64'(wbs_if.gnt), 64'd1);
      chk($sformatf("t3_dbg_acc_gnt_%0d", i), 64'(acc_if.gnt), 64'd0);
      if (i == 2) begin
        chk("t3_acc_rvalid_dbg", 64'(acc_if.rvalid), 64'd1);
        chk("t3_acc_rdata_dbg",  64'(acc_if.rdata),  64'h12345);
      end
      if (i == 3) begin
        chk("t3_wbs_rvalid", 64'(wbs_if.rvalid), 64'd1);
        chk("t3_wbs_rdata",  64'(wbs_if.rdata),  64'hB0B);
        chk("t3_acc_no_rv",  64'(acc_if.rvalid), 64'd0);
      end
      tick();
    end
    dbg = 1'b0;
    #2;
    chk("t3_post_acc_gnt", 64'(acc_if.gnt), 64'd1);
    chk("t3_post_wbs_gnt", 64'(wbs_if.gnt), 64'd0);
    tick();
    idle_reqs();

    // ---------------- Test 4: wbs write at top address, then acc read-back
    do_reset();
    wbs_if.req = 1'b1; wbs_if.we = 1'b1; wbs_if.addr = 9'd493; wbs_if.wdata = 55'h7FF;
    #2;
    chk("t4_wbs_gnt",  64'(wbs_if.gnt),  64'd1);
    chk("t4_web0_wr",  64'(mem_web0),    64'd0);
    chk("t4_addr0",    64'(mem_addr0),   64'd493);
    chk("t4_wpatch0",  64'(mem_wpatch0), 64'h7FF);
    tick();
    idle_reqs();
    acc_if.req = 1'b1; acc_if.addr = 9'd493;
    #2;
    chk("t4_acc_gnt",  64'(acc_if.gnt), 64'd1);
    chk("t4_web0_rd",  64'(mem_web0),   64'd1);
    tick();
    idle_reqs();
    #2;
    chk("t4_c2_wbs_rvalid", 64'(wbs_if.rvalid), 64'd0);
    tick();
    #2;
    chk("t4_c3_acc_rvalid", 64'(acc_if.rvalid), 64'd1);
    chk("t4_c3_acc_rdata",  64'(acc_if.rdata),  64'h7FF);
    chk("t4_c3_wbs_rvalid", 64'(wbs_if.rvalid), 64'd0);
    tick();

    // ---------------- Test 5: reset mid-read drops the return
    do_reset();
    acc_if.req = 1'b1; acc_if.addr = 9'd10;
    tick();
    idle_reqs();
    tick();
    #2;
    chk("t5_pre_rdata", 64'(acc_if.rdata), 64'hA0A);
    tick();
    acc_if.req = 1'b1; acc_if.addr = 9'd5;
    #2;
    chk("t5_rd_gnt", 64'(acc_if.gnt), 64'd1);
    tick();
    idle_reqs();
    rst = 1'b1;
    #2;
    chk("t5_hold_rdata", 64'(acc_if.rdata), 64'hA0A);
    tick();
    rst = 1'b0;
    acc_if.req = 1'b1; wbs_if.req = 1'b1;
    #2;
    chk("t5_no_rvalid",  64'(acc_if.rvalid), 64'd0);
    chk("t5_acc_rdata0", 64'(acc_if.rdata),  64'd0);
    chk("t5_wbs_rdata0", 64'(wbs_if.rdata),  64'd0);
    chk("t5_tie_acc",    64'(acc_if.gnt),    64'd1);
    chk("t5_tie_wbs",    64'(wbs_if.gnt),    64'd0);
    tick();
    idle_reqs();
    #2;
    chk("t5_late_rvalid", 64'(acc_if.rvalid), 64'd0);

    // ---------------- Test 6: idle cycle clears the burst count
    do_reset();
    acc_if.req = 1'b1; acc_if.addr = 9'd1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("t6_acc_gnt_%0d", i), 64'(acc_if.gnt), 64'd1);
      tick();
    end
    idle_reqs();
    #2;
    chk("t6_idle_csb0", 64'(mem_csb0), 64'd1);
    tick();
    acc_if.req = 1'b1; acc_if.addr = 9'd1;
    #2;
    chk("t6_single_gnt", 64'(acc_if.gnt), 64'd1);
    tick();
    wbs_if.req = 1'b1; wbs_if.addr = 9'd2;
    #2;
    chk("t6_tie_acc", 64'(acc_if.gnt), 64'd1);
    chk("t6_tie_wbs", 64'(wbs_if.gnt), 64'd0);
    tick();
    idle_reqs();
    tick();
    wbs_if.req = 1'b1; wbs_if.addr = 9'd2;
    #2;
    chk("t6_wbs_single", 64'(wbs_if.gnt), 64'd1);
    tick();
    idle_reqs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
